// File: rtl/iddr_responder_if.sv
// Instruction-fetch memory port between the icache (master) and the
// instruction-memory responder (slave).
//
// Handshake: the master raises icache_iddr_read with a stable address and
// keeps it high until it observes iddr_icache_resp. The responder raises
// iddr_icache_resp for exactly one cycle, with iddr_icache_rdata and
// iddr_err valid in that same cycle. There is no back-pressure on the
// response. Dropping read before the response abandons the request.
interface iddr_responder_if;
   logic [31:0] icache_iddr_addr;
   logic        icache_iddr_read;
   logic [31:0] iddr_icache_rdata;
   logic        iddr_icache_resp;
   logic        iddr_err;

   modport master (
      output icache_iddr_addr,
      output icache_iddr_read,
      input  iddr_icache_rdata,
      input  iddr_icache_resp,
      input  iddr_err
   );

   modport slave (
      input  icache_iddr_addr,
      input  icache_iddr_read,
      output iddr_icache_rdata,
      output iddr_icache_resp,
      output iddr_err
   );
endinterface

// File: rtl/iddr_responder.sv
// Instruction-memory stand-in below the icache. Serves single-word reads
// from a preloadable word array after a fixed latency and answers with a
// one-cycle response pulse. All outputs are registered.
module iddr_responder #(
   parameter int mem_words    = 4096,
   parameter int read_latency = 4
) (
   input  logic            clk,
   input  logic            rst,
   iddr_responder_if.slave bus,
   input  logic            ld_en,
   input  logic [31:0]     ld_addr,
   input  logic [31:0]     ld_data,
   output logic [1:0]      dbg_state
);

   localparam int         IW     = $clog2(mem_words);
   localparam logic [7:0] LAT_M1 = 8'(read_latency - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           oor_q, oor_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           resp_q, resp_d;
   logic           err_q, err_d;

   logic [IW-1:0]  req_idx;
   logic           req_oor;
   logic [IW-1:0]  ld_idx;
   logic           ld_oor;
   logic           unused_low_bits;

   logic [31:0]    mem [mem_words];

   // Byte addresses map to word indices; any bit above the index field
   // makes the address out of range. Byte-offset bits are don't-care.
   assign req_idx         = bus.icache_iddr_addr[IW+1:2];
   assign req_oor         = |bus.icache_iddr_addr[31:IW+2];
   assign ld_idx          = ld_addr[IW+1:2];
   assign ld_oor          = |ld_addr[31:IW+2];
   assign unused_low_bits = ^{bus.icache_iddr_addr[1:0], ld_addr[1:0]};

   // Preload port: writes land at the edge in every state; out-of-range
   // writes are dropped. The array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (ld_en && !ld_oor) begin
         mem[ld_idx] <= ld_data;
      end
   end

   // State and registered outputs; reset clears everything but the array.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         oor_q   <= 1'b0;
         rdata_q <= '0;
         resp_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         oor_q   <= oor_d;
         rdata_q <= rdata_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
      end
   end

   // Next-state and next-output logic. The array word is sampled at the
   // BUSY->RESP edge, so a preload to the same index at that edge is seen
   // only by later reads (read-before-write).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      oor_d   = oor_q;
      rdata_d = rdata_q;
      resp_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.icache_iddr_read) begin
               idx_d   = req_idx;
               oor_d   = req_oor;
               cnt_d   = LAT_M1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!bus.icache_iddr_read) begin
               state_d = IDLE;
            end else if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               rdata_d = oor_q ? 32'd0 : mem[idx_q];
               resp_d  = 1'b1;
               err_d   = oor_q;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.iddr_icache_rdata = rdata_q;
   assign bus.iddr_icache_resp  = resp_q;
   assign bus.iddr_err          = err_q;
   assign dbg_state             = state_q;

endmodule

// File: tb/tb_iddr_responder.sv
// Bench for iddr_responder: two instances (latency 4 and latency 1) share
// the preload port. Expected responses come from a word-array model and
// are queued at issue time; a negedge monitor pops and compares.
module tb_iddr_responder;

   localparam int MW   = 4096;
   localparam int IW   = $clog2(MW);
   localparam int LAT0 = 4;
   localparam int LAT1 = 1;
   localparam int W    = 65;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        rd [2];
   logic [31:0] ad [2];
   logic [1:0]  dbg0, dbg1;

   int n_pass   = 0;
   int n_checks = 0;
   int cyc      = 0;

   // entry = {expected cycle, err, rdata}
   logic [W-1:0] exp0_q[$];
   logic [W-1:0] exp1_q[$];
   logic [31:0]  ref_mem[int];
   int           ld_list[$];
   logic [31:0]  last_rdata [2];

   iddr_responder_if bus0 ();
   iddr_responder_if bus1 ();

   assign bus0.icache_iddr_read = rd[0];
   assign bus0.icache_iddr_addr = ad[0];
   assign bus1.icache_iddr_read = rd[1];
   assign bus1.icache_iddr_addr = ad[1];

   iddr_responder #(.mem_words(MW), .read_latency(LAT0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .dbg_state(dbg0)
   );

   iddr_responder #(.mem_words(MW), .read_latency(LAT1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .dbg_state(dbg1)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int lat_of(input int w);
      return (w == 0) ? LAT0 : LAT1;
   endfunction

   function automatic bit is_oor(input logic [31:0] a);
      return (a >> (IW + 2)) != 32'd0;
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) % MW);
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d);
      if (!is_oor(a)) begin
         ref_mem[idx_of(a)] = d;
         ld_list.push_back(idx_of(a));
      end
   endtask

   task automatic push_exp(input int w, input logic [31:0] a, input int k);
      logic        e;
      logic [31:0] d;
      e = is_oor(a);
      d = e ? 32'd0 : ref_mem[idx_of(a)];
      if (w == 0) exp0_q.push_back({32'(k + lat_of(w)), e, d});
      else        exp1_q.push_back({32'(k + lat_of(w)), e, d});
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic resp_of(input int w);
      return (w == 0) ? bus0.iddr_icache_resp : bus1.iddr_icache_resp;
   endfunction

   function automatic logic err_of(input int w);
      return (w == 0) ? bus0.iddr_err : bus1.iddr_err;
   endfunction

   function automatic logic [31:0] rdata_of(input int w);
      return (w == 0) ? bus0.iddr_icache_rdata : bus1.iddr_icache_rdata;
   endfunction

   task automatic mon_one(input int w);
      logic [W-1:0] e;
      if (err_of(w) && !resp_of(w)) begin
         n_checks++;
         $display("FAIL err_without_resp dut%0d: got err=1 expected err=0 (cycle %0d)", w, cyc);
      end
      if (resp_of(w)) begin
         if ((w == 0 && exp0_q.size() == 0) || (w == 1 && exp1_q.size() == 0)) begin
            n_checks++;
            $display("FAIL stray_resp dut%0d: got resp=1 expected resp=0 (cycle %0d)", w, cyc);
         end else begin
            e = (w == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
            check($sformatf("resp_cycle dut%0d", w), 32'(cyc), e[64:33]);
            check($sformatf("resp_err dut%0d", w), {31'd0, err_of(w)}, {31'd0, e[32]});
            check($sformatf("resp_data dut%0d", w), rdata_of(w), e[31:0]);
            last_rdata[w] = e[31:0];
         end
      end
   endtask

   always @(negedge clk) begin
      mon_one(0);
      mon_one(1);
   end

   // ---------------- driver tasks ----------------
   task automatic do_load(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      model_write(a, d);
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Waits for the response, scrambling the address meanwhile; returns in
   // the response cycle. keep=1 leaves read high for a back-to-back request.
   task automatic wait_resp(input int w, input bit keep);
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (resp_of(w)) seen = 1'b1;
         else ad[w] = $urandom;
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL resp_timeout dut%0d: got no resp expected resp within 300 cycles", w);
      end
      if (!keep) rd[w] = 1'b0;
   endtask

   task automatic do_read(input int w, input logic [31:0] a, input bit keep);
      @(negedge clk);
      ad[w] = a; rd[w] = 1'b1;
      push_exp(w, a, cyc + 1);
      wait_resp(w, keep);
   endtask

   // Read and preload of the same index accepted at the same edge.
   task automatic read_with_load(input int w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      ad[w] = a; rd[w] = 1'b1;
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      model_write(a, d);
      push_exp(w, a, cyc + 1);
      @(negedge clk);
      ld_en = 1'b0;
      wait_resp(w, 1'b0);
   endtask

   // Preload to the read's index at the edge that produces the response.
   task automatic collide(input logic [31:0] a, input logic [31:0] d);
      int k;
      @(negedge clk);
      ad[0] = a; rd[0] = 1'b1;
      k = cyc + 1;
      push_exp(0, a, k);
      while (cyc < k + LAT0 - 1) @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      model_write(a, d);
      @(negedge clk);
      ld_en = 1'b0;
      rd[0] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic abort_test(input logic [31:0] a);
      @(negedge clk);
      ad[0] = a; rd[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rd[0] = 1'b0;
      repeat (LAT0 + 3) @(negedge clk);
      check("abort_state_idle", {30'd0, dbg0}, 32'd0);
      check("abort_rdata_kept", bus0.iddr_icache_rdata, last_rdata[0]);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          w, prev_w, idx;
      bit          keep, prev_keep;
      logic [31:0] a;

      rst = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      rd[0] = 1'b1; ad[0] = 32'h14;
      rd[1] = 1'b0; ad[1] = 32'h0;
      last_rdata[0] = '0; last_rdata[1] = '0;

      // Preload while held in reset with read asserted.
      do_load(32'h14, 32'hDEADBEEF);
      for (int i = 0; i < 15; i++) begin
         idx = $urandom_range(6, MW - 1);
         do_load(32'(idx) << 2, $urandom);
      end
      check("reset_resp", {31'd0, bus0.iddr_icache_resp}, 32'd0);
      check("reset_err", {31'd0, bus0.iddr_err}, 32'd0);
      check("reset_rdata", bus0.iddr_icache_rdata, 32'd0);
      check("reset_state", {30'd0, dbg0}, 32'd0);

      // Release: first accept at the first edge after release.
      @(negedge clk);
      rst = 1'b1;
      push_exp(0, 32'h14, cyc + 1);
      wait_resp(0, 1'b0);

      do_read(0, 32'h16, 1'b0);
      do_read(0, 32'h0001_0000, 1'b0);
      do_load(32'h0001_0014, 32'h1234_5678);
      do_read(0, 32'h14, 1'b0);

      abort_test(32'h14);

      // Back-to-back with read held high.
      do_read(0, 32'h14, 1'b1);
      do_read(0, 32'(ld_list[1]) << 2, 1'b0);
      do_read(1, 32'h14, 1'b1);
      do_read(1, 32'(ld_list[2]) << 2, 1'b0);
      do_read(1, 32'hFFFF_FFFC, 1'b0);

      collide(32'h14, 32'h1);
      do_read(0, 32'h14, 1'b0);

      read_with_load(0, 32'h20, 32'hCAFE_0001);
      read_with_load(1, 32'h24, 32'hCAFE_0002);

      // Randomized traffic.
      prev_keep = 1'b0; prev_w = 0;
      for (int i = 0; i < 30; i++) begin
         if (prev_keep) w = prev_w;
         else begin
            w = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
               idx = $urandom_range(0, MW - 1);
               do_load(32'(idx) << 2, $urandom);
            end
         end
         if ($urandom_range(0, 5) == 0) a = $urandom | 32'h0001_0000;
         else a = (32'(ld_list[$urandom_range(0, ld_list.size() - 1)]) << 2)
                  | 32'($urandom_range(0, 3));
         keep = (i < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
         do_read(w, a, keep);
         prev_keep = keep; prev_w = w;
      end

      // Reset mid-BUSY: the transaction is dropped.
      @(negedge clk);
      ad[0] = 32'h14; rd[0] = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      #1 check("midbusy_rst_state", {30'd0, dbg0}, 32'd0);
      rd[0] = 1'b0;
      last_rdata[0] = '0; last_rdata[1] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (LAT0 + 4) @(negedge clk);
      check("midbusy_no_resp_state", {30'd0, dbg0}, 32'd0);
      check("midbusy_rdata_reset", bus0.iddr_icache_rdata, 32'd0);

      // Reset during the response cycle clears outputs without a clock edge.
      do_read(0, 32'h0002_0000, 1'b1);
      #1 rst = 1'b0;
      #1;
      check("async_rst_resp", {31'd0, bus0.iddr_icache_resp}, 32'd0);
      check("async_rst_err", {31'd0, bus0.iddr_err}, 32'd0);
      check("async_rst_rdata", bus0.iddr_icache_rdata, 32'd0);
      rd[0] = 1'b0;
      last_rdata[0] = '0; last_rdata[1] = '0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Array survives reset.
      do_read(0, 32'h20, 1'b0);
      do_read(1, 32'h14, 1'b0);

      repeat (10) @(negedge clk);
      check("exp0_q_drained", 32'(exp0_q.size()), 32'd0);
      check("exp1_q_drained", 32'(exp1_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
